// File: rtl/ooo_pkg.sv
// Shared types and constants for the rename front end: register index types,
// RISC-V major opcodes and the decode/rename payload structs.
package ooo_pkg;
  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;

  typedef logic [6:0] preg_t;
  typedef logic [4:0] areg_t;
  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_JALR   = 7'b1100111;

  typedef struct packed {
    areg_t rd;
    areg_t rs1;
    areg_t rs2;
    logic  writes_rd;
    logic  uses_rs2;
  } dec_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
  } ren_t;
endpackage

// File: rtl/ooo_rename_frontend_fetch.sv
// Instruction memory, fetch, decode and a generic 2-entry skid buffer.
module ooo_imem #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 512,
  parameter int  AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  T              wr_data,
  output T              rdata
);
  T mem [DEPTH];

  // Write port is reserved for a future loader; the front end ties it off.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (en) rdata <= mem[addr];
  end
endmodule

module ooo_fetch #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_ready,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  output logic          out_valid
);
  logic [31:0] pc;
  logic        unused_pc_bits;

  // The memory output register is the fetch output: only read when it can be replaced.
  assign imem_en        = !out_valid || out_ready;
  assign imem_addr      = pc[AW+1:2];
  assign unused_pc_bits = ^{pc[31:AW+2], pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      out_valid <= 1'b0;
    end else if (imem_en) begin
      pc        <= pc + 32'd4;
      out_valid <= 1'b1;
    end
  end
endmodule

module ooo_decode import ooo_pkg::*; #(
  parameter type T = logic [31:0]
) (
  input  T     inst,
  output dec_t dec
);
  opcode_t opc;
  logic    wr_class;
  logic    unused_fields;

  assign opc           = inst[6:0];
  assign unused_fields = ^{inst[31:25], inst[14:12]};

  always_comb begin
    dec      = '0;
    wr_class = 1'b0;
    dec.rd   = inst[11:7];
    dec.rs1  = inst[19:15];
    dec.rs2  = inst[24:20];
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: wr_class = 1'b1;
      default:                      wr_class = 1'b0;
    endcase
    dec.writes_rd = wr_class && (dec.rd != '0);
    dec.uses_rs2  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  end
endmodule

module ooo_skid #(
  parameter type D = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  D     in_data,
  output logic out_valid,
  input  logic out_ready,
  output D     out_data
);
  D           buf_q [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] cnt;
  logic       push, pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = buf_q[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/ooo_rename_frontend_rename.sv
// Register rename: map table plus FIFO free list of physical destinations.
module ooo_free_list import ooo_pkg::*; #(
  parameter int N_PREGS = 128,
  parameter int N_AREGS = 32,
  parameter int DEPTH   = N_PREGS - N_AREGS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pop,
  output preg_t      head,
  output logic [6:0] count,
  input  logic       push,
  input  preg_t      push_preg
);
  preg_t      entries [DEPTH];
  logic [6:0] rd_ptr, wr_ptr;
  logic       do_pop, do_push;

  assign head    = entries[rd_ptr];
  assign do_pop  = pop && (count != 7'd0);
  assign do_push = push && ((count != 7'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= preg_t'(N_AREGS + i);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 7'(DEPTH);
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_preg;
        wr_ptr <= (wr_ptr == 7'(DEPTH - 1)) ? 7'd0 : wr_ptr + 7'd1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == 7'(DEPTH - 1)) ? 7'd0 : rd_ptr + 7'd1;
      count <= count + 7'(do_push) - 7'(do_pop);
    end
  end
endmodule

module ooo_rename import ooo_pkg::*; #(
  parameter int N_PREGS = 128,
  parameter int N_AREGS = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  dec_t  in_dec,
  output logic  rename_ready,
  input  logic  downstream_ready,
  output logic  out_valid,
  output preg_t prs1,
  output preg_t prs2,
  output preg_t prd
);
  preg_t      map_q [N_AREGS];
  preg_t      fl_head;
  logic [6:0] fl_count;
  logic       has_free, alloc;

  assign has_free  = (fl_count != 7'd0);
  assign out_valid = in_valid && (!in_dec.writes_rd || has_free);
  // An instruction without a destination never needs the free list, so it drains even when empty.
  assign rename_ready = downstream_ready && (has_free || (in_valid && !in_dec.writes_rd));
  assign alloc        = out_valid && downstream_ready && in_dec.writes_rd;

  assign prs1 = map_q[in_dec.rs1];
  assign prs2 = in_dec.uses_rs2 ? map_q[in_dec.rs2] : '0;
  assign prd  = in_dec.writes_rd ? fl_head : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_AREGS; i++) map_q[i] <= preg_t'(i);
    end else if (alloc) begin
      map_q[in_dec.rd] <= fl_head;
    end
  end

  ooo_free_list #(.N_PREGS(N_PREGS), .N_AREGS(N_AREGS)) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop       (alloc),
    .head      (fl_head),
    .count     (fl_count),
    .push      (1'b0),
    .push_preg ('0)
  );
endmodule

// File: rtl/ooo_rename_frontend.sv
// Front end top: imem -> fetch -> decode -> skid -> rename -> skid (always drained).
module ooo_rename_frontend #(
  parameter type T          = logic [31:0],
  parameter int  NUM_PREGS  = 128,
  parameter int  NUM_AREGS  = 32,
  parameter int  IMEM_DEPTH = 512
) (
  input logic clk,
  input logic rst
);
  import ooo_pkg::*;
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          imem_en, f_valid, f_ready;
  logic [AW-1:0] imem_addr;
  T              f_inst;
  dec_t          f_dec, r_in_dec;
  logic          r_in_valid, r_ready;
  logic          rename_to_skid_valid, rs_ready;
  preg_t         rename_to_skid_prs1, rename_to_skid_prs2, rename_to_skid_prd;
  ren_t          rs_data, dispatch_data_unused;
  logic          dispatch_valid_unused;

  ooo_imem #(.T(T), .DEPTH(IMEM_DEPTH)) instruction_memory (
    .clk     (clk),
    .en      (imem_en),
    .addr    (imem_addr),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_data ('0),
    .rdata   (f_inst)
  );

  ooo_fetch #(.AW(AW)) fetch_inst (
    .clk       (clk),
    .rst       (rst),
    .out_ready (f_ready),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .out_valid (f_valid)
  );

  ooo_decode #(.T(T)) decode_inst (
    .inst (f_inst),
    .dec  (f_dec)
  );

  ooo_skid #(.D(dec_t)) decode_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (f_valid),
    .in_ready  (f_ready),
    .in_data   (f_dec),
    .out_valid (r_in_valid),
    .out_ready (r_ready),
    .out_data  (r_in_dec)
  );

  ooo_rename #(.N_PREGS(NUM_PREGS), .N_AREGS(NUM_AREGS)) rename_inst (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (r_in_valid),
    .in_dec           (r_in_dec),
    .rename_ready     (r_ready),
    .downstream_ready (rs_ready),
    .out_valid        (rename_to_skid_valid),
    .prs1             (rename_to_skid_prs1),
    .prs2             (rename_to_skid_prs2),
    .prd              (rename_to_skid_prd)
  );

  assign rs_data = '{prs1: rename_to_skid_prs1, prs2: rename_to_skid_prs2, prd: rename_to_skid_prd};

  ooo_skid #(.D(ren_t)) rename_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rename_to_skid_valid),
    .in_ready  (rs_ready),
    .in_data   (rs_data),
    .out_valid (dispatch_valid_unused),
    .out_ready (1'b1),
    .out_data  (dispatch_data_unused)
  );
endmodule

// File: tb/tb_ooo_rename_frontend.sv
// Randomized bench for the rename front end against an in-order rename reference model.
module tb_ooo_rename_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ooo_rename_frontend dut (.clk(clk), .rst(rst));

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [512];
  int mmap [32];
  int fl [$];
  int nidx, cyc, fires, first_fire_cyc, last_fire_cyc, rel_cyc;
  int first_prd, last_prd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [6:0] opc, input int rd, input int rs1, input int imm);
    logic [11:0] im = 12'(imm);
    return {im, 5'(rs1), 3'b000, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic bit m_writes(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    bit cls = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h37) ||
              (op == 7'h17) || (op == 7'h6f) || (op == 7'h67);
    return cls && (ins[11:7] != 5'd0);
  endfunction

  function automatic bit m_uses2(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    return (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mmap[i] = i;
    fl.delete();
    for (int p = 32; p < 128; p++) fl.push_back(p);
    nidx = 0; fires = 0; first_fire_cyc = -100; last_fire_cyc = -100;
    first_prd = -1; last_prd = -1;
  endfunction

  task automatic monitor();
    logic [31:0] ins;
    bit w, fire;
    int e1, e2, ed;
    check("fl_count", 32'(dut.rename_inst.u_free_list.count), fl.size());
    ins = (nidx < 512) ? prog[nidx] : 32'd0;
    w = m_writes(ins);
    if (w && fl.size() == 0) begin
      check("stall_valid", 32'(dut.rename_to_skid_valid), 0);
      check("stall_ready", 32'(dut.rename_inst.rename_ready), 0);
    end
    fire = dut.rename_to_skid_valid && dut.rename_inst.rename_ready;
    if (fire) begin
      e1 = mmap[ins[19:15]];
      e2 = m_uses2(ins) ? mmap[ins[24:20]] : 0;
      ed = (w && fl.size() > 0) ? fl[0] : 0;
      check("prs1", 32'(dut.rename_to_skid_prs1), e1);
      check("prs2", 32'(dut.rename_to_skid_prs2), e2);
      check("prd", 32'(dut.rename_to_skid_prd), ed);
      if (w && fl.size() > 0) begin
        void'(fl.pop_front());
        mmap[ins[11:7]] = ed;
      end
      if (fires == 0) begin
        first_fire_cyc = cyc;
        first_prd = int'(dut.rename_to_skid_prd);
      end
      last_fire_cyc = cyc;
      last_prd = int'(dut.rename_to_skid_prd);
      fires++;
      nidx++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (!rst) monitor();
  endtask

  // Holds reset for n cycles, preloads the program, checks reset state, then releases.
  task automatic reset_and_load(input int n);
    rst = 1'b1;
    for (int i = 0; i < 512; i++) dut.instruction_memory.mem[i] = prog[i];
    repeat (n) step();
    check("rst_valid", 32'(dut.rename_to_skid_valid), 0);
    check("rst_count", 32'(dut.rename_inst.u_free_list.count), 96);
    model_reset();
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    cyc = 0;
    model_reset();

    // Directed program: ADDI x1,x0,10 ; ADD x2,x1,x0 ; ADDI x3,x3,1 chain
    for (int i = 0; i < 512; i++) prog[i] = 32'd0;
    prog[0] = itype(7'h13, 1, 0, 10);
    prog[1] = rtype(2, 1, 0);
    for (int i = 2; i < 200; i++) prog[i] = itype(7'h13, 3, 3, 1);
    reset_and_load(5);
    for (int i = 0; i < 300 && fl.size() != 0; i++) step();
    check("a_first_latency_ok", 32'((first_fire_cyc - rel_cyc) <= 5), 1);
    check("a_first_prd", first_prd, 32);
    check("a_fires", fires, 96);
    check("a_throughput", last_fire_cyc - first_fire_cyc, fires - 1);
    check("a_last_prd", last_prd, 127);
    repeat (8) step();
    check("a_count_empty", 32'(dut.rename_inst.u_free_list.count), 0);
    check("a_no_more_fires", fires, 96);

    // Reset after 10 allocations, same program
    reset_and_load(2);
    for (int i = 0; i < 60 && fl.size() > 86; i++) step();
    check("b_ten_allocs", fl.size(), 86);
    rst = 1'b1;
    step();
    check("b_mid_rst_valid", 32'(dut.rename_to_skid_valid), 0);
    check("b_mid_rst_count", 32'(dut.rename_inst.u_free_list.count), 96);
    reset_and_load(1);
    repeat (10) step();
    check("b_first_prd", first_prd, 32);
    check("b_first_latency_ok", 32'((first_fire_cyc - rel_cyc) <= 5), 1);

    // rd=x0 instructions keep flowing with an empty free list
    for (int i = 0; i < 512; i++) prog[i] = 32'd0;
    for (int i = 0; i < 96; i++) prog[i] = itype(7'h13, 5, 5, 1);
    for (int i = 96; i < 101; i++) prog[i] = itype(7'h13, 0, 0, 0);
    prog[101] = rtype(6, 5, 5);
    reset_and_load(2);
    repeat (200) step();
    check("c_fires", fires, 101);
    check("c_last_prd_zero", last_prd, 0);
    check("c_count_empty", 32'(dut.rename_inst.u_free_list.count), 0);

    // Random instruction mix
    for (int i = 0; i < 512; i++) begin
      logic [6:0] ops [10];
      logic [31:0] w;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h0f};
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      prog[i] = w;
    end
    reset_and_load(2);
    repeat (300) step();
    check("d_some_fires", 32'(fires > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
